// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data bus between the EX/MEM register (master) and the data memory (slave).
//   MemRead/MemWrite : load / store request
//   addr, wdata      : byte address and store data
//   rdata            : load data, or the old word for a store
//   stall            : freeze the pipeline while the access is in flight
//   ready            : one-cycle response strobe
//   misalign         : the completed access had addr[1:0] != 0
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        ready;
    logic        misalign;
    modport master (output MemRead, MemWrite, addr, wdata, input rdata, stall, ready, misalign);
    modport slave (input MemRead, MemWrite, addr, wdata, output rdata, stall, ready, misalign);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory that stalls the pipeline for LATENCY cycles per access.
//   clk, rst : clock and synchronous active-high reset (also clears the array)
//   bus      : slave end of the MEM-stage data bus (see dmem_responder_if)
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    state_t state, state_n;
    logic [3:0] cnt;
    logic [ADDR_W+1:0] addr_q, c_addr;
    logic [31:0] wdata_q, c_wdata, rdata_q;
    logic wr_q, c_wr, req, commit, misal, mis_q, unused_hi;
    logic [ADDR_W-1:0] idx;
    logic [31:0] mem [2**ADDR_W];
    assign unused_hi = ^bus.addr[31:ADDR_W+2];
    always_comb begin
        req = bus.MemRead | bus.MemWrite;
        state_n = state == DONE ? IDLE :
                  state == BUSY ? (cnt == 4'd1 ? DONE : BUSY) :
                  req ? (LATENCY == 1 ? DONE : BUSY) : IDLE;
        commit = state_n == DONE && state != DONE;
        // With LATENCY=1 the commit edge is the accept edge, so use the live request.
        c_addr = state == IDLE ? bus.addr[ADDR_W+1:0] : addr_q;
        c_wdata = state == IDLE ? bus.wdata : wdata_q;
        c_wr = state == IDLE ? bus.MemWrite : wr_q;
        idx = c_addr[ADDR_W+1:2];
        misal = c_addr[1:0] != 2'b00;
        bus.stall = (state == IDLE && req) || state == BUSY;
        bus.ready = state == DONE;
        bus.rdata = rdata_q;
        bus.misalign = mis_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            rdata_q <= '0;
            mis_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            wr_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                cnt <= CNT_INIT;
                addr_q <= bus.addr[ADDR_W+1:0];
                wdata_q <= bus.wdata;
                wr_q <= bus.MemWrite;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rdata_q <= misal ? '0 : mem[idx];
                mis_q <= misal;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else if (commit && c_wr && !misal) begin
            mem[idx] <= c_wdata;
        end
    end
endmodule
